// File: rtl/cdb_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | cdb_arbiter_pkg : shared CDB widths, ROB tag range and source indices       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef CDB_ARBITER_DEFINES
`define CDB_ARBITER_DEFINES
`define ROB_RANGE 3:0
`endif

package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = $bits(logic [`ROB_RANGE]);
  localparam int CDB_DATA_W = 32;

  localparam int SRC_ALU   = 0;
  localparam int SRC_LOAD  = 1;
  localparam int SRC_STORE = 2;
  localparam int SRC_BR    = 3;

endpackage

`default_nettype wire

// File: rtl/cdb_rr_pick.sv
// +----------------------------------------------------------------------------+
// | cdb_rr_pick : rotating first-set-bit picker, one-hot grant plus index      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  logic [NUM_SRC-1:0] rot;

  // Rotate so that position 0 is the source at ptr, pick the first set bit,
  // then map the rotated position back to the real source index.
  always_comb begin
    int j;
    rot   = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j      = (k + int'(ptr)) % NUM_SRC;
      rot[k] = req[j];
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rot[k] && !any) begin
        any      = 1'b1;
        j        = (k + int'(ptr)) % NUM_SRC;
        idx      = SRC_W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | cdb_arbiter : per-source holding buffers shared onto one registered CDB    |
// | Option: CDB_ROUND_ROBIN_EN selects rotating priority (else fixed, src 0)   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  req_tag,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_SRC-1:0] buf_valid;
  logic [TAG_W-1:0]   buf_tag  [NUM_SRC];
  logic [DATA_W-1:0]  buf_data [NUM_SRC];

  logic [NUM_SRC-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_any;
  logic [SRC_W-1:0]   w_ptr;

`ifdef CDB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] rr_ptr;
  assign w_ptr = rr_ptr;
`else
  assign w_ptr = '0;
`endif

  cdb_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req   (buf_valid),
    .ptr   (w_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // A granted buffer drains this cycle, so it may be refilled in the same cycle.
  assign req_ready = {NUM_SRC{rdy_in & ~flush_in}} & (~buf_valid | w_grant);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_valid <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
`ifdef CDB_ROUND_ROBIN_EN
      rr_ptr    <= '0;
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        buf_valid <= '0;
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= w_any;
        if (w_any) begin
          cdb_tag  <= buf_tag[w_idx];
          cdb_data <= buf_data[w_idx];
          cdb_src  <= w_idx;
`ifdef CDB_ROUND_ROBIN_EN
          rr_ptr   <= (w_idx == SRC_W'(NUM_SRC-1)) ? '0 : w_idx + 1'b1;
`endif
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (w_grant[i]) begin
            buf_valid[i] <= 1'b0;
          end
          // Tag 0 completes the handshake but is dropped: it never reaches the bus.
          if (req_valid[i] && req_ready[i]) begin
            buf_valid[i] <= (req_tag[i*TAG_W +: TAG_W] != '0);
            buf_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
            buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
